// File: rtl/ftdi_tx_arbiter.sv
// Round-robin arbiter merging a register-response byte stream and a data stream into the
// FTDI write FIFO. Define FTDI_TX_TAG_EN to prefix each burst with a source tag byte.
module ftdi_tx_arbiter #(
    parameter int unsigned MAX_BURST = 16,
    parameter logic [7:0]  RSP_TAG   = 8'h52,
    parameter logic [7:0]  STR_TAG   = 8'h53
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       rsp_valid,
    input  logic [7:0] rsp_data,
    output logic       rsp_ready,
    input  logic       str_valid,
    input  logic [7:0] str_data,
    output logic       str_ready,
    input  logic       wf_full,
    output logic       wf_wr,
    output logic [7:0] wf_data,
    output logic [1:0] grant
);

`ifdef FTDI_TX_TAG_EN
    typedef enum logic [1:0] {StIdle, StTag, StRsp, StStr} state_e;
`else
    typedef enum logic [1:0] {StIdle, StRsp, StStr} state_e;
`endif

    localparam logic [7:0] MaxBurst = 8'(MAX_BURST);

    state_e     state_q, state_d;
    logic       last_q, last_d;  // 1: stream was served last
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] cnt_inc;
    logic       pick_str;

    assign cnt_inc  = cnt_q + 8'd1;
    assign pick_str = str_valid & (~rsp_valid | ~last_q);

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        rsp_ready = 1'b0;
        str_ready = 1'b0;
        wf_wr     = 1'b0;
        // wf_data is don't-care while wf_wr is low; the tag of the current owner is a cheap default
        wf_data   = last_q ? STR_TAG : RSP_TAG;
        grant     = 2'b00;

        unique case (state_q)
            StIdle: begin
                if (rsp_valid || str_valid) begin
                    last_d = pick_str;
                    cnt_d  = 8'd0;
`ifdef FTDI_TX_TAG_EN
                    state_d = StTag;
`else
                    state_d = pick_str ? StStr : StRsp;
`endif
                end
            end
`ifdef FTDI_TX_TAG_EN
            StTag: begin
                grant = last_q ? 2'b10 : 2'b01;
                if (!wf_full) begin
                    wf_wr   = 1'b1;
                    state_d = last_q ? StStr : StRsp;
                end
            end
`endif
            StRsp: begin
                grant     = 2'b01;
                rsp_ready = rsp_valid & ~wf_full;
                if (!rsp_valid) begin
                    state_d = StIdle;
                end else if (rsp_ready) begin
                    wf_wr   = 1'b1;
                    wf_data = rsp_data;
                    cnt_d   = cnt_inc;
                    if (cnt_inc == MaxBurst) state_d = StIdle;
                end
            end
            StStr: begin
                grant     = 2'b10;
                str_ready = str_valid & ~wf_full;
                if (!str_valid) begin
                    state_d = StIdle;
                end else if (str_ready) begin
                    wf_wr   = 1'b1;
                    wf_data = str_data;
                    cnt_d   = cnt_inc;
                    if (cnt_inc == MaxBurst) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: doc/ftdi_tx_arbiter.md
FTDI_TX_ARBITER -- requirements
Module: ftdi_tx_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 16; the maximum number of data bytes per grant, legal range 1..255.
REQ-002 SHALL have parameter RSP_TAG, default 8'h52; the tag byte that precedes a response burst.
REQ-003 SHALL have parameter STR_TAG, default 8'h53; the tag byte that precedes a stream burst.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clk, input, 1 bit; the system clock, which is also the write clock of the FTDI write FIFO.
REQ-006 SHALL have port res_n, input, 1 bit; asynchronous active-low reset.
REQ-007 SHALL have port rsp_valid, input, 1 bit; register read-response byte available.
REQ-008 SHALL have port rsp_data, input, 8 bits; register read-response byte.
REQ-009 SHALL have port rsp_ready, output, 1 bit; response byte accepted this cycle.
REQ-010 SHALL have port str_valid, input, 1 bit; stream byte available.
REQ-011 SHALL have port str_data, input, 8 bits; stream byte.
REQ-012 SHALL have port str_ready, output, 1 bit; stream byte accepted this cycle.
REQ-013 SHALL have port wf_full, input, 1 bit; write FIFO full.
REQ-014 SHALL have port wf_wr, output, 1 bit; write FIFO write enable.
REQ-015 SHALL have port wf_data, output, 8 bits; write FIFO data.
REQ-016 SHALL have port grant, output, 2 bits; one-hot owner, bit0 = response, bit1 = stream.

Function
REQ-017 SHALL implement the states IDLE, TAG, RSP and STR.
REQ-018 SHALL keep a last-owner flag and a burst counter of 8 bits.
REQ-019 In IDLE, a single requester (valid=1) SHALL be granted; if both request, the one not last served SHALL be granted (round-robin).
REQ-020 On grant, the block SHALL go to TAG (macro defined) or directly to RSP/STR (macro undefined); the burst counter SHALL clear, last-owner SHALL update, and grant SHALL assert from the next cycle.
REQ-021 In RSP, rsp_ready SHALL equal rsp_valid & ~wf_full; str_ready SHALL be 0; STR SHALL behave symmetrically.
REQ-022 On a data handshake, the block SHALL assert wf_wr=1 and present wf_data=selected data combinationally in the same cycle; 0 cycles of latency.
REQ-023 Each data handshake SHALL increment the burst counter.
REQ-024 After the handshake that makes the count equal MAX_BURST, the block SHALL go to IDLE next cycle.
REQ-025 If the owner's valid is 0 in RSP/STR, the block SHALL go to IDLE next cycle without a write.
REQ-026 If wf_full=1, there SHALL be no handshake and no write, the counter SHALL hold, and grant SHALL be retained (stall).
REQ-027 IDLE SHALL last exactly one cycle between bursts; grant SHALL be 2'b00 in IDLE.
REQ-028 wf_wr SHALL never assert with wf_full=1.
REQ-029 rsp_ready and str_ready SHALL never both be 1.

Reset
REQ-030 res_n=0 SHALL force, asynchronously, state=IDLE, counter=0, last-owner=stream (so the response wins the first contention), grant=0, rsp_ready=0, str_ready=0 and wf_wr=0.
REQ-031 On reset mid-burst, the partial burst SHALL be abandoned; no write SHALL occur in the release cycle.

Configuration
REQ-032 With FTDI_TX_TAG_EN defined: TAG SHALL write the RSP_TAG or STR_TAG byte to the FIFO when wf_full=0 (stall otherwise), then enter the data state; the tag SHALL not count toward MAX_BURST and both ready outputs SHALL be 0 in TAG.
REQ-033 With FTDI_TX_TAG_EN undefined: the TAG state SHALL be absent and the FIFO SHALL carry raw data only.

Verification
REQ-034 Tag disabled; rsp_valid held with bytes 01..03 then deasserted -> wf_data 01,02,03 on consecutive cycles; grant=01; IDLE follows.
REQ-035 Both valid continuously, MAX_BURST=4 -> 4 response bytes, 1 IDLE cycle, 4 stream bytes, alternating; never 5 consecutive bytes from one source.
REQ-036 wf_full=1 for 3 cycles during the second stream byte -> wf_wr=0 and str_ready=0 for those 3 cycles; byte written once after release; counter unaffected.
REQ-037 Tag enabled; single stream request of 2 bytes AA,BB -> FIFO receives 53,AA,BB.
REQ-038 res_n pulsed low during byte 3 of a 16-byte burst -> outputs 0 immediately; after release with both valid, response granted first.
